// File: rtl/regfile_io_write_arbiter_if.sv
// Regfile write-port bundle: CPU writeback request/stall on one side,
// the arbitrated regfile write strobe/address/data on the other.
interface regfile_io_write_arbiter_if;
  logic        cpu_we;
  logic [4:0]  cpu_wreg;
  logic [31:0] cpu_wdata;
  logic        cpu_stall;
  logic        rf_we;
  logic [4:0]  rf_wreg;
  logic [31:0] rf_wdata;

  modport master (
    output cpu_we, cpu_wreg, cpu_wdata,
    input  cpu_stall, rf_we, rf_wreg, rf_wdata
  );

  modport slave (
    input  cpu_we, cpu_wreg, cpu_wdata,
    output cpu_stall, rf_we, rf_wreg, rf_wdata
  );
endinterface

// File: rtl/regfile_io_write_arbiter.sv
// Shares the regfile write port between CPU writeback and the game-I/O mirror
// slots (r12/r13/r15/r16), and snoops r14/r17/r18 into registered shadows.
module regfile_io_write_arbiter #(
  parameter int STARVE_LIMIT = 8,
  parameter int CNT_W        = 4
) (
  input  logic                              clock,
  input  logic                              ctrl_reset,
  regfile_io_write_arbiter_if.slave         bus,
  input  logic [9:0]                        curScore,
  input  logic [10:0]                       rx,
  input  logic [10:0]                       ry,
  input  logic [3:0]                        gameVar,
  output logic [9:0]                        nextScore,
  output logic [10:0]                       offsetX,
  output logic [10:0]                       offsetY,
  output logic                              io_busy
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic [31:0]      sample    [4];
  logic [31:0]      committed [4];
  logic [3:0]       dirty;
  logic [1:0]       rrPtr;
  logic [1:0]       selSlot;
  logic [1:0]       probe;
  logic             slotFound;
  logic [CNT_W-1:0] waitCnt;
  logic [CNT_W-1:0] waitNext;
  logic             cpuReq;
  logic             cpuGrant;
  logic             ioGrant;

  function automatic logic [4:0] slotReg(input logic [1:0] k);
    case (k)
      2'd0:    slotReg = 5'd12;
      2'd1:    slotReg = 5'd13;
      2'd2:    slotReg = 5'd15;
      default: slotReg = 5'd16;
    endcase
  endfunction

  always_comb begin
    dirty = '0;
    for (int k = 0; k < 4; k++) begin
      dirty[k] = (sample[k] != committed[k]);
    end
  end

  assign io_busy = |dirty;

  // A raised stall means the CPU is being held off for exactly one forced I/O write.
  always_comb begin
    cpuReq   = bus.cpu_we && (bus.cpu_wreg != 5'd0);
    cpuGrant = 1'b0;
    ioGrant  = 1'b0;
    if (!ctrl_reset) begin
      if (bus.cpu_stall && io_busy) begin
        ioGrant = 1'b1;
      end else if (cpuReq) begin
        cpuGrant = 1'b1;
      end else if (io_busy) begin
        ioGrant = 1'b1;
      end
    end
  end

  always_comb begin
    selSlot   = rrPtr;
    slotFound = 1'b0;
    probe     = rrPtr;
    for (int i = 0; i < 4; i++) begin
      probe = rrPtr + 2'(i);
      if (!slotFound && dirty[probe]) begin
        selSlot   = probe;
        slotFound = 1'b1;
      end
    end
  end

  always_comb begin
    bus.rf_we    = 1'b0;
    bus.rf_wreg  = 5'd0;
    bus.rf_wdata = 32'd0;
    if (cpuGrant) begin
      bus.rf_we    = 1'b1;
      bus.rf_wreg  = bus.cpu_wreg;
      bus.rf_wdata = bus.cpu_wdata;
    end else if (ioGrant) begin
      bus.rf_we    = 1'b1;
      bus.rf_wreg  = slotReg(selSlot);
      bus.rf_wdata = sample[selSlot];
    end
  end

  always_comb begin
    if (ioGrant || !io_busy) begin
      waitNext = '0;
    end else if (waitCnt >= LIMIT) begin
      waitNext = LIMIT;
    end else begin
      waitNext = waitCnt + 1'b1;
    end
  end

  always_ff @(posedge clock or posedge ctrl_reset) begin
    if (ctrl_reset) begin
      for (int k = 0; k < 4; k++) begin
        sample[k]    <= '0;
        committed[k] <= '0;
      end
      rrPtr         <= '0;
      waitCnt       <= '0;
      bus.cpu_stall <= 1'b0;
    end else begin
      sample[0] <= {28'd0, gameVar};
      sample[1] <= {22'd0, curScore};
      sample[2] <= {21'd0, rx};
      sample[3] <= {21'd0, ry};
      if (ioGrant) begin
        committed[selSlot] <= sample[selSlot];
        rrPtr              <= selSlot + 2'd1;
      end
      waitCnt       <= waitNext;
      bus.cpu_stall <= (waitNext == LIMIT);
    end
  end

  // Shadows follow whatever actually reached the regfile, CPU or I/O.
  always_ff @(posedge clock or posedge ctrl_reset) begin
    if (ctrl_reset) begin
      nextScore <= '0;
      offsetX   <= '0;
      offsetY   <= '0;
    end else if (bus.rf_we) begin
      case (bus.rf_wreg)
        5'd14:   nextScore <= bus.rf_wdata[9:0];
        5'd17:   offsetX   <= bus.rf_wdata[10:0];
        5'd18:   offsetY   <= bus.rf_wdata[10:0];
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_io_write_arbiter.sv
// Self-checking bench: cycle model of the write-port arbitration rules compared
// every cycle, plus directed scenarios with hand-computed expectations.
module tb_regfile_io_write_arbiter;

  localparam int STARVE = 8;

  logic        clock = 1'b0;
  logic        ctrl_reset = 1'b1;
  logic [9:0]  curScore = '0;
  logic [10:0] rx = '0;
  logic [10:0] ry = '0;
  logic [3:0]  gameVar = '0;
  logic [9:0]  nextScore;
  logic [10:0] offsetX;
  logic [10:0] offsetY;
  logic        io_busy;

  int compared = 0;
  int mismatched = 0;

  regfile_io_write_arbiter_if bus ();

  regfile_io_write_arbiter #(
    .STARVE_LIMIT(STARVE),
    .CNT_W(4)
  ) dut (
    .clock(clock),
    .ctrl_reset(ctrl_reset),
    .bus(bus),
    .curScore(curScore),
    .rx(rx),
    .ry(ry),
    .gameVar(gameVar),
    .nextScore(nextScore),
    .offsetX(offsetX),
    .offsetY(offsetY),
    .io_busy(io_busy)
  );

  always #5 clock = ~clock;

  // Model state: what each slot last saw, what the regfile holds, and the arbiter bookkeeping.
  logic [31:0] mSample [4] = '{32'd0, 32'd0, 32'd0, 32'd0};
  logic [31:0] mCommit [4] = '{32'd0, 32'd0, 32'd0, 32'd0};
  int          slotRegs [4] = '{12, 13, 15, 16};
  int          mPtr = 0;
  int          mWait = 0;
  logic        mStall = 1'b0;
  logic [9:0]  mNext = '0;
  logic [10:0] mOffX = '0;
  logic [10:0] mOffY = '0;

  function automatic void predict(output logic pWe, output logic [4:0] pReg,
                                  output logic [31:0] pData, output logic pIo,
                                  output int pSlot, output logic pBusy);
    logic found;
    int   k;
    pWe = 1'b0; pReg = '0; pData = '0; pIo = 1'b0; pSlot = 0; pBusy = 1'b0; found = 1'b0;
    for (int i = 0; i < 4; i++) if (mSample[i] != mCommit[i]) pBusy = 1'b1;
    if (!ctrl_reset) begin
      if (pBusy && (mStall || !(bus.cpu_we && bus.cpu_wreg != 5'd0))) begin
        for (int i = 0; i < 4; i++) begin
          k = (mPtr + i) % 4;
          if (!found && mSample[k] != mCommit[k]) begin
            pSlot = k;
            found = 1'b1;
          end
        end
        pIo = 1'b1; pWe = 1'b1;
        pReg = 5'(slotRegs[pSlot]);
        pData = mSample[pSlot];
      end else if (bus.cpu_we && bus.cpu_wreg != 5'd0) begin
        pWe = 1'b1; pReg = bus.cpu_wreg; pData = bus.cpu_wdata;
      end
    end
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  initial begin : modelProc
    logic       uWe, uIo, uBusy;
    logic [4:0] uReg;
    logic [31:0] uData;
    int         uSlot;
    forever begin
      @(posedge clock or posedge ctrl_reset);
      if (ctrl_reset) begin
        for (int i = 0; i < 4; i++) begin mSample[i] = '0; mCommit[i] = '0; end
        mPtr = 0; mWait = 0; mStall = 1'b0; mNext = '0; mOffX = '0; mOffY = '0;
      end else begin
        predict(uWe, uReg, uData, uIo, uSlot, uBusy);
        if (uWe && uReg == 5'd14) mNext = uData[9:0];
        if (uWe && uReg == 5'd17) mOffX = uData[10:0];
        if (uWe && uReg == 5'd18) mOffY = uData[10:0];
        if (uIo) begin
          mCommit[uSlot] = mSample[uSlot];
          mPtr = (uSlot + 1) % 4;
        end
        if (uIo || !uBusy) mWait = 0;
        else if (mWait < STARVE) mWait = mWait + 1;
        mStall = (mWait == STARVE);
        mSample[0] = {28'd0, gameVar};
        mSample[1] = {22'd0, curScore};
        mSample[2] = {21'd0, rx};
        mSample[3] = {21'd0, ry};
      end
    end
  end

  initial begin : compareProc
    logic       eWe, eIo, eBusy;
    logic [4:0] eReg;
    logic [31:0] eData;
    int         eSlot;
    forever begin
      @(negedge clock);
      predict(eWe, eReg, eData, eIo, eSlot, eBusy);
      checkOutput("cmp rf_we", 32'(bus.rf_we), 32'(eWe));
      checkOutput("cmp rf_wreg", 32'(bus.rf_wreg), 32'(eReg));
      checkOutput("cmp rf_wdata", bus.rf_wdata, eData);
      checkOutput("cmp cpu_stall", 32'(bus.cpu_stall), 32'(mStall));
      checkOutput("cmp io_busy", 32'(io_busy), 32'(eBusy));
      checkOutput("cmp nextScore", 32'(nextScore), 32'(mNext));
      checkOutput("cmp offsetX", 32'(offsetX), 32'(mOffX));
      checkOutput("cmp offsetY", 32'(offsetY), 32'(mOffY));
    end
  end

  task automatic step();
    @(posedge clock);
    #2;
  endtask

  task automatic applyStimulus(input logic we, input logic [4:0] wreg, input logic [31:0] wdata);
    bus.cpu_we    = we;
    bus.cpu_wreg  = wreg;
    bus.cpu_wdata = wdata;
  endtask

  task automatic doReset();
    ctrl_reset = 1'b1;
    applyStimulus(1'b0, 5'd0, 32'd0);
    @(posedge clock);
    @(posedge clock);
    #2;
    ctrl_reset = 1'b0;
  endtask

  task automatic expectWrite(input string name, input logic [4:0] wreg, input logic [31:0] wdata);
    @(negedge clock);
    checkOutput({name, " rf_we"}, 32'(bus.rf_we), 32'd1);
    checkOutput({name, " rf_wreg"}, 32'(bus.rf_wreg), 32'(wreg));
    checkOutput({name, " rf_wdata"}, bus.rf_wdata, wdata);
  endtask

  initial begin : watchdog
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  logic [4:0]  ioRegs [4] = '{5'd12, 5'd13, 5'd15, 5'd16};
  logic [31:0] ioVals [4] = '{32'd3, 32'd7, 32'd9, 32'd11};

  initial begin : stimulus
    applyStimulus(1'b0, 5'd0, 32'd0);
    doReset();

    // Reset state and a single rx injection on an idle port.
    @(negedge clock);
    checkOutput("reset rf_we", 32'(bus.rf_we), 32'd0);
    checkOutput("reset cpu_stall", 32'(bus.cpu_stall), 32'd0);
    checkOutput("reset io_busy", 32'(io_busy), 32'd0);
    checkOutput("reset nextScore", 32'(nextScore), 32'd0);
    step();
    rx = 11'd100;
    @(negedge clock);
    checkOutput("rx100 not yet sampled", 32'(bus.rf_we), 32'd0);
    step();
    expectWrite("rx100", 5'd15, 32'd100);
    step();
    @(negedge clock);
    checkOutput("rx100 io_busy clear", 32'(io_busy), 32'd0);
    checkOutput("rx100 rf_we idle", 32'(bus.rf_we), 32'd0);

    // Four slots change together: round-robin from slot 0.
    step();
    rx = '0;
    doReset();
    gameVar = 4'd3; curScore = 10'd7; rx = 11'd9; ry = 11'd11;
    for (int i = 0; i < 4; i++) begin
      step();
      expectWrite("burst", ioRegs[i], ioVals[i]);
      checkOutput("burst io_busy", 32'(io_busy), 32'd1);
    end
    step();
    @(negedge clock);
    checkOutput("burst io_busy clear", 32'(io_busy), 32'd0);

    // CPU hogs the port; starvation guard forces the rx write.
    step();
    applyStimulus(1'b1, 5'd5, 32'h0000_ABCD);
    rx = 11'd42;
    expectWrite("starve cpu first", 5'd5, 32'h0000_ABCD);
    for (int i = 0; i < STARVE; i++) begin
      step();
      @(negedge clock);
      checkOutput("starve wait stall", 32'(bus.cpu_stall), 32'd0);
      checkOutput("starve wait rf_wreg", 32'(bus.rf_wreg), 32'd5);
    end
    step();
    @(negedge clock);
    checkOutput("starve stall", 32'(bus.cpu_stall), 32'd1);
    checkOutput("starve rf_wreg", 32'(bus.rf_wreg), 32'd15);
    checkOutput("starve rf_wdata", bus.rf_wdata, 32'd42);
    step();
    @(negedge clock);
    checkOutput("starve stall clear", 32'(bus.cpu_stall), 32'd0);
    checkOutput("starve resume rf_wreg", 32'(bus.rf_wreg), 32'd5);
    checkOutput("starve io_busy clear", 32'(io_busy), 32'd0);

    // Shadow snooping of r14/r17/r18.
    step();
    applyStimulus(1'b1, 5'd14, 32'h0000_03F5);
    expectWrite("shadow r14", 5'd14, 32'h0000_03F5);
    step();
    applyStimulus(1'b1, 5'd17, 32'd2047);
    expectWrite("shadow r17", 5'd17, 32'd2047);
    checkOutput("shadow nextScore", 32'(nextScore), 32'h3F5);
    step();
    applyStimulus(1'b1, 5'd18, 32'd5);
    expectWrite("shadow r18", 5'd18, 32'd5);
    checkOutput("shadow offsetX", 32'(offsetX), 32'd2047);
    step();
    applyStimulus(1'b0, 5'd0, 32'd0);
    @(negedge clock);
    checkOutput("shadow offsetY", 32'(offsetY), 32'd5);

    // A write to r0 is idle, so a pending ry goes through.
    step();
    applyStimulus(1'b1, 5'd0, 32'h0000_DEAD);
    ry = 11'd300;
    @(negedge clock);
    checkOutput("r0 write dropped", 32'(bus.rf_we), 32'd0);
    step();
    expectWrite("r0 ry inject", 5'd16, 32'd300);
    step();
    applyStimulus(1'b0, 5'd0, 32'd0);

    // Async reset in the middle of a forced stall.
    step();
    applyStimulus(1'b1, 5'd5, 32'd1234);
    rx = 11'd77;
    for (int i = 0; i < STARVE; i++) step();
    step();
    @(negedge clock);
    checkOutput("midreset stall before", 32'(bus.cpu_stall), 32'd1);
    #3;
    ctrl_reset = 1'b1;
    #1;
    checkOutput("midreset cpu_stall", 32'(bus.cpu_stall), 32'd0);
    checkOutput("midreset rf_we", 32'(bus.rf_we), 32'd0);
    checkOutput("midreset nextScore", 32'(nextScore), 32'd0);
    checkOutput("midreset offsetX", 32'(offsetX), 32'd0);
    checkOutput("midreset offsetY", 32'(offsetY), 32'd0);
    applyStimulus(1'b0, 5'd0, 32'd0);
    @(posedge clock);
    @(posedge clock);
    #2;
    ctrl_reset = 1'b0;
    ioVals[2] = 32'd77;
    ioVals[3] = 32'd300;
    for (int i = 0; i < 4; i++) begin
      step();
      expectWrite("reinject", ioRegs[i], ioVals[i]);
    end
    step();
    @(negedge clock);
    checkOutput("reinject io_busy clear", 32'(io_busy), 32'd0);

    step();
    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
